mips_multicycle: RTL

Parametrised multicycle MIPS-style core that replaces the single-cycle top. It fetches and executes one instruction at a time through a five-state FSM. It talks to separate instruction and data memories over req/ready handshakes, so memories with any number of wait states are supported. Data width, address width and reset PC are parameters. Retire and halt status outputs are exposed for system integration and verification.

---
 rtl/mips_pkg.sv | 95 +++++++++
 rtl/mips_mc_ctrl.sv | 135 +++++++++++++
 rtl/mips_multicycle.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALU/FSM/PC-select enums, instruction field layout
// and the opcode decoder shared by the multicycle core. No ports.
package mips_pkg;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int IMM_HI = 11;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = 12;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'h00;
    localparam opcode_t OP_SUB  = 5'h01;
    localparam opcode_t OP_AND  = 5'h02;
    localparam opcode_t OP_OR   = 5'h03;
    localparam opcode_t OP_XOR  = 5'h04;
    localparam opcode_t OP_SLT  = 5'h05;
    localparam opcode_t OP_ADDI = 5'h08;
    localparam opcode_t OP_LW   = 5'h10;
    localparam opcode_t OP_SW   = 5'h11;
    localparam opcode_t OP_BEQ  = 5'h18;
    localparam opcode_t OP_BNE  = 5'h19;
    localparam opcode_t OP_J    = 5'h1C;
    localparam opcode_t OP_HALT = 5'h1F;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_BR,
        PC_JMP
    } pc_sel_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    use_imm;
        logic    writes;
        logic    is_lw;
        logic    is_sw;
        logic    is_br;
        logic    is_bne;
        logic    is_j;
        logic    is_halt;
    } dec_t;

    // Unknown opcodes fall out with every flag clear and retire as a NOP.
    function automatic dec_t decode_op(input opcode_t op);
        dec_t d;
        d        = '0;
        d.alu_op = ALU_ADD;
        case (op)
            OP_ADD:  d.writes = 1'b1;
            OP_SUB:  begin d.writes = 1'b1; d.alu_op = ALU_SUB; end
            OP_AND:  begin d.writes = 1'b1; d.alu_op = ALU_AND; end
            OP_OR:   begin d.writes = 1'b1; d.alu_op = ALU_OR;  end
            OP_XOR:  begin d.writes = 1'b1; d.alu_op = ALU_XOR; end
            OP_SLT:  begin d.writes = 1'b1; d.alu_op = ALU_SLT; end
            OP_ADDI: begin d.writes = 1'b1; d.use_imm = 1'b1; end
            OP_LW:   begin d.is_lw = 1'b1; d.use_imm = 1'b1; end
            OP_SW:   begin d.is_sw = 1'b1; d.use_imm = 1'b1; end
            OP_BEQ:  d.is_br = 1'b1;
            OP_BNE:  begin d.is_br = 1'b1; d.is_bne = 1'b1; end
            OP_J:    d.is_j = 1'b1;
            OP_HALT: d.is_halt = 1'b1;
            default: d.alu_op = ALU_ADD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: five-state fetch/decode/exec/mem/wb FSM plus opcode decode.
// In: clk, reset, op, eq, imem/dmem ready. Out: req strobes, datapath loads, alu_op, pc_sel, retire, halted.
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  opcode_t op,
    input  logic    eq,
    input  logic    imem_ready,
    input  logic    dmem_ready,
    output logic    imem_req,
    output logic    dmem_req,
    output logic    dmem_we,
    output logic    retire,
    output logic    halted,
    output logic    ir_load,
    output logic    ab_load,
    output logic    ex_load,
    output logic    mdr_load,
    output logic    reg_we,
    output logic    wb_mem,
    output logic    use_imm,
    output alu_op_t alu_op,
    output pc_sel_t pc_sel
);

    state_t state;
    dec_t   dec;
    logic   short_op;
    logic   br_taken;
    logic   mem_done;

    assign dec      = decode_op(op);
    assign short_op = !(dec.is_lw || dec.is_sw || dec.writes);
    assign br_taken = dec.is_br && (eq ^ dec.is_bne);
    assign mem_done = (state == S_MEM) && dmem_req && dmem_ready;

    assign alu_op   = dec.alu_op;
    assign use_imm  = dec.use_imm;
    assign wb_mem   = dec.is_lw;
    assign ir_load  = (state == S_FETCH) && imem_req && imem_ready;
    assign ab_load  = (state == S_DECODE);
    assign ex_load  = (state == S_EXEC);
    assign mdr_load = mem_done && !dmem_we;
    assign reg_we   = (state == S_WB);

    // Entering FETCH raises imem_req on the same edge so a zero-wait
    // fetch takes one cycle; only the cycle after reset fetches late.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (dec.is_halt) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end else if (dec.is_lw || dec.is_sw) begin
                        state    <= S_MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= dec.is_sw;
                    end else if (dec.writes) begin
                        state <= S_WB;
                    end else begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // A store retires on whichever cycle dmem_ready arrives, so retire
    // is decoded from the registered state rather than registered itself.
    always_comb begin
        retire = 1'b0;
        pc_sel = PC_HOLD;
        unique case (1'b1)
            state == S_EXEC: begin
                retire = short_op;
                if (br_taken) begin
                    pc_sel = PC_BR;
                end else if (dec.is_j) begin
                    pc_sel = PC_JMP;
                end else if (short_op && !dec.is_halt) begin
                    pc_sel = PC_INC;
                end
            end
            state == S_MEM: begin
                if (mem_done && dmem_we) begin
                    retire = 1'b1;
                    pc_sel = PC_INC;
                end
            end
            state == S_WB: begin
                retire = 1'b1;
                pc_sel = PC_INC;
            end
            default: pc_sel = PC_HOLD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS-style core; register file, ALU and PC here.
// Ports: clk/reset, imem req/addr/ready/rdata, dmem req/we/addr/wdata/ready/rdata, retire, halted.
module mips_multicycle
    import mips_pkg::*;
#(
    parameter int            WIDTH    = 32,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [AW-1:0]    imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [AW-1:0]    dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ready,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             retire,
    output logic             halted
);

    logic [31:0]      ir;
    logic [AW-1:0]    pc;
    logic [WIDTH-1:0] rf [32];
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] aluout;
    logic [WIDTH-1:0] mdr;

    opcode_t          op;
    logic [4:0]       rd;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [WIDTH-1:0] imm_sx;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] wb_data;
    logic [AW-1:0]    pc_inc;
    logic [AW-1:0]    pc_br;
    logic [AW-1:0]    pc_j;

    logic    ir_load;
    logic    ab_load;
    logic    ex_load;
    logic    mdr_load;
    logic    reg_we;
    logic    wb_mem;
    logic    use_imm;
    alu_op_t alu_op;
    pc_sel_t pc_sel;

    assign op     = ir[OP_HI:OP_LO];
    assign rd     = ir[RD_HI:RD_LO];
    assign rs     = ir[RS_HI:RS_LO];
    assign rt     = ir[RT_HI:RT_LO];
    assign imm_sx = {{(WIDTH-IMM_W){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};

    assign imem_addr = pc;
    assign alu_b     = use_imm ? imm_sx : b;
    assign wb_data   = wb_mem ? mdr : aluout;
    assign pc_inc    = pc + AW'(1);
    assign pc_br     = pc + AW'(1) + imm_sx[AW-1:0];
    assign pc_j      = AW'(ir[IMM_HI:IMM_LO]);

    mips_mc_ctrl u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .eq         (a == b),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .retire     (retire),
        .halted     (halted),
        .ir_load    (ir_load),
        .ab_load    (ab_load),
        .ex_load    (ex_load),
        .mdr_load   (mdr_load),
        .reg_we     (reg_we),
        .wb_mem     (wb_mem),
        .use_imm    (use_imm),
        .alu_op     (alu_op),
        .pc_sel     (pc_sel)
    );

    always_comb begin
        alu_y = '0;
        unique case (alu_op)
            ALU_ADD:   alu_y = a + alu_b;
            ALU_SUB:   alu_y = a - alu_b;
            ALU_AND:   alu_y = a & alu_b;
            ALU_OR:    alu_y = a | alu_b;
            ALU_XOR:   alu_y = a ^ alu_b;
            ALU_SLT:   alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(alu_b)};
            ALU_PASSB: alu_y = alu_b;
            default:   alu_y = '0;
        endcase
    end

    // r0 is never written, so reading it always yields the reset zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (reg_we && rd != 5'd0) begin
            rf[rd] <= wb_data;
        end
    end

    // dmem_addr/wdata load only in EXEC, so they hold through MEM waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir         <= '0;
            pc         <= PC_RESET;
            a          <= '0;
            b          <= '0;
            aluout     <= '0;
            mdr        <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            if (ir_load) begin
                ir <= imem_rdata;
            end
            if (ab_load) begin
                a <= rf[rs];
                b <= rf[rt];
            end
            if (ex_load) begin
                aluout     <= alu_y;
                dmem_addr  <= alu_y[AW-1:0];
                dmem_wdata <= b;
            end
            if (mdr_load) begin
                mdr <= dmem_rdata;
            end
            unique case (pc_sel)
                PC_INC:  pc <= pc_inc;
                PC_BR:   pc <= pc_br;
                PC_JMP:  pc <= pc_j;
                default: pc <= pc;
            endcase
        end
    end

endmodule
